mean_filter_scheduler: RTL and testbench

- Frame-level sequencer for the MeanFilter datapath.
- On a start pulse it walks every window position of an image in raster order and requests each window from the upstream window source.
- It holds the filter's enable high while the pipeline is in use.
- It carries a coordinate/valid tag alongside the filter's fixed latency, so each filtered pixel leaves with its column, row, border flag and end-of-frame marker.

---
 rtl/mean_filter_pkg.sv | 29 ++
 rtl/mean_filter_tag_pipe.sv | 30 +++
 rtl/mean_filter_scheduler.sv | 164 ++++++++++++++++
 tb/tb_mean_filter_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mean_filter_pkg.sv
// Shared types and helpers for the MeanFilter frame scheduler.
package mean_filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int TAG_COORD_WIDTH = 11;

    typedef struct packed {
        logic                       valid;
        logic [TAG_COORD_WIDTH-1:0] col;
        logic [TAG_COORD_WIDTH-1:0] row;
        logic                       border;
        logic                       last;
    } tag_t;

    function automatic int latency(input int sum_stage);
        return sum_stage + 1;
    endfunction

    function automatic int border_radius(input int window_width);
        return (window_width - 1) / 2;
    endfunction

endpackage

// File: rtl/mean_filter_tag_pipe.sv
// Tag shift register that tracks the MeanFilter pipeline, one stage per filter cycle.
module mean_filter_tag_pipe
    import mean_filter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    // Held empty while the filter is disabled so a new frame never starts with a stale tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (enable) begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end else begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mean_filter_scheduler.sv
// Frame sequencer for MeanFilter: raster window requests plus a latency-matched coordinate tag.
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | requesting windows in raster order
//  DRAIN | flushing the last L filter cycles
//  DONE  | one-cycle done pulse
module mean_filter_scheduler
    import mean_filter_pkg::*;
#(
    parameter int COLOR_WIDTH  = 12,
    parameter int WINDOW_WIDTH = 3,
    parameter int SUM_STAGE    = 3,
    parameter int COORD_WIDTH  = TAG_COORD_WIDTH,
    parameter int BORDER_MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COORD_WIDTH-1:0] img_width,
    input  logic [COORD_WIDTH-1:0] img_height,
    output logic                   busy,
    output logic                   done,
    output logic                   win_req,
    input  logic                   win_valid,
    output logic [COORD_WIDTH-1:0] win_col,
    output logic [COORD_WIDTH-1:0] win_row,
    output logic                   flt_enable,
    input  logic                   flt_ready,
    input  logic [COLOR_WIDTH-1:0] flt_data,
    output logic                   out_valid,
    output logic [COLOR_WIDTH-1:0] out_data,
    output logic [COORD_WIDTH-1:0] out_col,
    output logic [COORD_WIDTH-1:0] out_row,
    output logic                   out_border,
    output logic                   out_last,
    output logic                   err
);

    localparam int L       = latency(SUM_STAGE);
    localparam int R       = border_radius(WINDOW_WIDTH);
    localparam int CW      = COORD_WIDTH;
    localparam int DRAIN_W = $clog2(L) + 1;

    state_t               state;
    logic [CW-1:0]        width_q, height_q, col, row;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 xfer, at_last_col, at_last_row, border;
    tag_t                 tag_in, tag_out;

    assign xfer        = win_req & win_valid;
    assign at_last_col = (col == width_q - CW'(1));
    assign at_last_row = (row == height_q - CW'(1));

    // Widened by one bit so w-1-R cannot underflow on tiny images.
    assign border = ({1'b0, col} < (CW+1)'(R))
                  | (({1'b0, col} + (CW+1)'(R + 1)) > {1'b0, width_q})
                  | ({1'b0, row} < (CW+1)'(R))
                  | (({1'b0, row} + (CW+1)'(R + 1)) > {1'b0, height_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            col        <= '0;
            row        <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            win_req    <= 1'b0;
            flt_enable <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    width_q  <= img_width;
                    height_q <= img_height;
                    col      <= '0;
                    row      <= '0;
                    busy     <= 1'b1;
                    if (img_width == '0 || img_height == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= RUN;
                        win_req    <= 1'b1;
                        flt_enable <= 1'b1;
                    end
                end
                RUN: if (xfer) begin
                    if (at_last_col) begin
                        col <= '0;
                        if (at_last_row) begin
                            state     <= DRAIN;
                            win_req   <= 1'b0;
                            drain_cnt <= DRAIN_W'(L - 1);
                        end else begin
                            row <= row + CW'(1);
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                DRAIN: if (drain_cnt == '0) begin
                    state      <= DONE;
                    flt_enable <= 1'b0;
                    done       <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt - DRAIN_W'(1);
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign win_col = col;
    assign win_row = row;

    always_comb begin
        tag_in        = '0;
        tag_in.valid  = xfer;
        tag_in.col    = TAG_COORD_WIDTH'(col);
        tag_in.row    = TAG_COORD_WIDTH'(row);
        tag_in.border = border;
        tag_in.last   = at_last_col & at_last_row;
    end

    mean_filter_tag_pipe #(
        .DEPTH (L)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .enable  (flt_enable),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign out_valid = tag_out.valid & flt_enable;

    always_comb begin
        out_data   = '0;
        out_col    = '0;
        out_row    = '0;
        out_border = 1'b0;
        out_last   = 1'b0;
        if (out_valid) begin
            out_col    = CW'(tag_out.col);
            out_row    = CW'(tag_out.row);
            out_border = tag_out.border;
            out_last   = tag_out.last;
            out_data   = (BORDER_MODE == 1 && tag_out.border) ? '0 : flt_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        err <= 1'b0;
        else if (out_valid & ~flt_ready) err <= 1'b1;
    end

endmodule

// File: tb/tb_mean_filter_scheduler.sv
// Scoreboard bench for mean_filter_scheduler (BORDER_MODE=1, L=4, R=1).
`timescale 1ns/1ps
module tb_mean_filter_scheduler;

    localparam int CW  = 11;
    localparam int DW  = 12;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          win_valid = 1'b1;
    logic          flt_ready = 1'b1;
    logic [CW-1:0] img_width = '0;
    logic [CW-1:0] img_height = '0;
    logic          busy, done, win_req, flt_enable, out_valid, out_border, out_last, err;
    logic [CW-1:0] win_col, win_row, out_col, out_row;
    logic [DW-1:0] flt_data, out_data;

    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign flt_data = DW'(cyc * 37 + 5);

    mean_filter_scheduler #(
        .COLOR_WIDTH (DW), .WINDOW_WIDTH (3), .SUM_STAGE (3),
        .COORD_WIDTH (CW), .BORDER_MODE (1)
    ) dut (
        .clk (clk), .rst (rst), .start (start),
        .img_width (img_width), .img_height (img_height),
        .busy (busy), .done (done), .win_req (win_req), .win_valid (win_valid),
        .win_col (win_col), .win_row (win_row), .flt_enable (flt_enable),
        .flt_ready (flt_ready), .flt_data (flt_data), .out_valid (out_valid),
        .out_data (out_data), .out_col (out_col), .out_row (out_row),
        .out_border (out_border), .out_last (out_last), .err (err)
    );

    typedef struct {
        int            col;
        int            row;
        bit            border;
        bit            last;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_cmp = 0, n_bad = 0;
    int n_xfer = 0, n_out = 0, n_done = 0, n_last = 0, n_int = 0;
    int exp_w = 0, exp_h = 0, exp_col = 0, exp_row = 0;
    bit stall_mode = 0;

    function automatic bit is_border(int c, int r, int w, int h);
        return (c < 1) || (c + 2 > w) || (r < 1) || (r + 2 > h);
    endfunction

    // Stall pattern: win_valid alternates every cycle while busy.
    always @(posedge clk) begin
        #1;
        if (stall_mode && busy) win_valid = ~win_valid;
    end

    // Monitor: push expectations on each handshake, pop and compare on each output.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) n_done++;
            if (win_req && win_valid) begin
                n_cmp++;
                if (win_col !== CW'(exp_col) || win_row !== CW'(exp_row)) begin
                    n_bad++;
                    $display("FAIL win_coord: got (%0d,%0d) want (%0d,%0d) cyc %0d",
                             win_col, win_row, exp_col, exp_row, cyc);
                end
                mon_e.col    = exp_col;
                mon_e.row    = exp_row;
                mon_e.border = is_border(exp_col, exp_row, exp_w, exp_h);
                mon_e.last   = (exp_col == exp_w - 1) && (exp_row == exp_h - 1);
                mon_e.cyc    = cyc + LAT;
                mon_e.data   = mon_e.border ? '0 : DW'((cyc + LAT) * 37 + 5);
                sb.push_back(mon_e);
                n_xfer++;
                if (exp_col == exp_w - 1) begin
                    exp_col = 0;
                    exp_row++;
                end else begin
                    exp_col++;
                end
            end
            if (out_valid) begin
                n_out++;
                if (out_last) n_last++;
                if (!out_border) n_int++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_unexpected: got (%0d,%0d) at cyc %0d, want no output",
                             out_col, out_row, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_col !== CW'(mon_e.col) || out_row !== CW'(mon_e.row) ||
                        out_border !== mon_e.border || out_last !== mon_e.last ||
                        out_data !== mon_e.data || cyc != mon_e.cyc) begin
                        n_bad++;
                        $display("FAIL out_pixel: got col %0d row %0d b %0b l %0b d %h cyc %0d; want col %0d row %0d b %0b l %0b d %h cyc %0d",
                                 out_col, out_row, out_border, out_last, out_data, cyc,
                                 mon_e.col, mon_e.row, mon_e.border, mon_e.last, mon_e.data, mon_e.cyc);
                    end
                end
            end else begin
                n_cmp++;
                if ({out_data, out_col, out_row, out_border, out_last} !== '0) begin
                    n_bad++;
                    $display("FAIL out_idle_zero: got d %h col %0d row %0d b %0b l %0b, want all 0",
                             out_data, out_col, out_row, out_border, out_last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_frame(input int w, input int h, input int poke_at,
                             output int s, output int first_req, output int last_req,
                             output int busy_cnt, output int en_cnt, output int done_cyc);
        n_xfer = 0; n_out = 0; n_done = 0; n_last = 0; n_int = 0;
        first_req = -1; last_req = -1; busy_cnt = 0; en_cnt = 0; done_cyc = -1;
        tick();
        img_width = CW'(w); img_height = CW'(h); start = 1'b1;
        exp_w = w; exp_h = h; exp_col = 0; exp_row = 0;
        s = cyc;
        tick();
        start = 1'b0;
        img_width = '0; img_height = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (flt_enable) en_cnt++;
            if (win_req) begin
                if (first_req < 0) first_req = cyc;
                last_req = cyc;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (poke_at >= 0 && cyc == s + poke_at) begin
                start = 1'b1; img_width = CW'(2); img_height = CW'(2);
            end else begin
                start = 1'b0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, win_req, flt_enable, out_valid, err, out_border, out_last} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, done, win_req, flt_enable, out_valid, err, out_border, out_last});
        end
        n_cmp++;
        if ({win_col, win_row, out_col, out_row, out_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {win_col, win_row, out_col, out_row, out_data});
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_frame();
        int s, fr, lr, bc, ec, dc;
        win_valid = 1'b1;
        run_frame(4, 3, -1, s, fr, lr, bc, ec, dc);
        n_cmp++; if (fr != s + 1) begin n_bad++; $display("FAIL frame_first_req: got %0d want %0d", fr - s, 1); end
        n_cmp++; if (lr != s + 12) begin n_bad++; $display("FAIL frame_last_req: got %0d want %0d", lr - s, 12); end
        n_cmp++; if (dc != s + 17) begin n_bad++; $display("FAIL frame_done_cyc: got %0d want %0d", dc - s, 17); end
        n_cmp++; if (bc != 17) begin n_bad++; $display("FAIL frame_busy_cycles: got %0d want 17", bc); end
        n_cmp++; if (ec != 16) begin n_bad++; $display("FAIL frame_enable_cycles: got %0d want 16", ec); end
        n_cmp++; if (n_xfer != 12 || n_out != 12) begin n_bad++; $display("FAIL frame_counts: got xfer %0d out %0d want 12/12", n_xfer, n_out); end
        n_cmp++; if (n_last != 1 || n_done != 1) begin n_bad++; $display("FAIL frame_last_done: got last %0d done %0d want 1/1", n_last, n_done); end
        n_cmp++; if (n_int != 2) begin n_bad++; $display("FAIL frame_interior: got %0d want 2", n_int); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL frame_sb_left: got %0d want 0", sb.size()); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL frame_err: got %b want 0", err); end
    endtask

    task automatic test_stall();
        int s, fr, lr, bc, ec, dc;
        win_valid = 1'b0;
        stall_mode = 1'b1;
        run_frame(2, 2, -1, s, fr, lr, bc, ec, dc);
        stall_mode = 1'b0;
        win_valid = 1'b1;
        n_cmp++; if (n_xfer != 4 || n_out != 4) begin n_bad++; $display("FAIL stall_counts: got xfer %0d out %0d want 4/4", n_xfer, n_out); end
        n_cmp++; if (dc != s + 12) begin n_bad++; $display("FAIL stall_done_cyc: got %0d want %0d", dc - s, 12); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL stall_sb_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_zero_dim();
        int s, fr, lr, bc, ec, dc;
        run_frame(0, 3, -1, s, fr, lr, bc, ec, dc);
        n_cmp++; if (dc != s + 1) begin n_bad++; $display("FAIL zero_done_cyc: got %0d want %0d", dc - s, 1); end
        n_cmp++; if (fr != -1 || ec != 0 || n_out != 0) begin n_bad++; $display("FAIL zero_activity: got req %0d en %0d out %0d want -1/0/0", fr, ec, n_out); end
        n_cmp++; if (n_done != 1 || bc != 1) begin n_bad++; $display("FAIL zero_done_busy: got done %0d busy %0d want 1/1", n_done, bc); end
    endtask

    task automatic test_reset_mid();
        int s, fr, lr, bc, ec, dc;
        int guard;
        n_xfer = 0;
        tick();
        img_width = CW'(4); img_height = CW'(3); start = 1'b1;
        exp_w = 4; exp_h = 3; exp_col = 0; exp_row = 0;
        tick();
        start = 1'b0;
        guard = 0;
        while (n_xfer < 5 && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        n_cmp++; if (n_xfer != 5) begin n_bad++; $display("FAIL rmid_xfers: got %0d want 5", n_xfer); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({flt_enable, win_req, busy, done, out_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL rmid_clear: got %b want 00000", {flt_enable, win_req, busy, done, out_valid});
        end
        sb.delete();
        n_done = 0;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d want 0", n_done); end
        run_frame(4, 3, -1, s, fr, lr, bc, ec, dc);
        n_cmp++; if (n_out != 12 || dc != s + 17) begin n_bad++; $display("FAIL rmid_rerun: got out %0d done %0d want 12/17", n_out, dc - s); end
    endtask

    task automatic test_err();
        int s, fr, lr, bc, ec, dc;
        flt_ready = 1'b0;
        run_frame(4, 3, 5, s, fr, lr, bc, ec, dc);
        flt_ready = 1'b1;
        n_cmp++; if (n_xfer != 12 || n_done != 1 || dc != s + 17) begin
            n_bad++;
            $display("FAIL busy_start_ignored: got xfer %0d done %0d at %0d want 12/1/17", n_xfer, n_done, dc - s);
        end
        tick();
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_zero_dim();
        test_reset_mid();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
